dsram_responder: RTL
====================

# dsram_responder

Data-side SRAM-like responder: the memory end of the request/`addr_ok`/`data_ok` interface that the MEM1/MEM2 stages drive and consume. It accepts one request per cycle, applies byte-lane writes and captures read words from an internal word-addressed RAM, and returns each transaction's `data_ok` (plus `rdata` for reads) in order after a fixed latency. It serves as the on-chip data RAM for SoC bring-up and as the bench-side memory model for the CPU core.

## Interface
Parameters:
- `ADDR_W`, default 12: word-address width; RAM depth is 2^ADDR_W words.
- `LATENCY`, default 2, legal 1..4: cycles from request acceptance to the matching `data_ok`.

Ports:
- `clk`  input  1: the only clock; all state changes on the rising edge.
- `rst`  input  1: synchronous, active-low reset (`RstEnable` == 1'b0).
- `data_req_i`  input  1: request valid.
- `data_wr_i`  input  1: 1 = store, 0 = load.
- `data_size_i`  input  2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `data_addr_i`  input  32: byte address.
- `data_wdata_i`  input  32: store data, lane-aligned by the requester.
- `data_addr_ok_o`  output  1: request accepted this cycle when high together with `data_req_i`.
- `data_data_ok_o`  output  1: one-cycle pulse, one per accepted transaction, loads and stores alike.
- `data_rdata_o`  output  32: full read word; valid only while `data_data_ok_o` is high for a load.

## Operation
- Handshake: a request is accepted in any cycle where `data_req_i && data_addr_ok_o`. Request signals are sampled only in that cycle.
- `data_addr_ok_o` is 1 every cycle after reset, except when the stall feature (see Configuration) forces it low. It is combinational from state only and never depends on `data_req_i`.
- The word index is `data_addr_i[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias.
- Byte enables come from size and `addr[1:0]`:
  - byte: enable bit a = addr[1:0].
  - half: 0011 if addr[1]=0, else 1100 (addr[0] ignored).
  - word: 1111 (addr[1:0] ignored).
- Store: enabled lanes of `data_wdata_i` are written into the RAM at the acceptance edge.
- Load: the full word at the index is read at acceptance, after any write accepted on an earlier cycle. Lane selection and extension are the requester's job.
- Accepted transactions enter a LATENCY-deep shift pipeline. Each stage holds a valid bit and a 32-bit data word. The pipeline advances every cycle unconditionally, because the requester has no back-pressure on `data_ok`.
- `data_data_ok_o` = valid bit of the last stage. `data_rdata_o` = data of the last stage. The data field is 0 for stores.
- Responses return strictly in acceptance order. Maximum outstanding transactions = LATENCY.

## Timing
- Reset values: `data_addr_ok_o`=0 during reset, 1 in the first cycle after `rst` rises; `data_data_ok_o`=0; `data_rdata_o`=0. All pipeline valid bits are cleared.
- Latency: a request accepted at edge N gives `data_data_ok_o` high in the cycle after edge N+LATENCY-1. With LATENCY=1 that is the cycle immediately after acceptance.
- Back-to-back: requests accepted on consecutive cycles give `data_ok` on consecutive cycles. Throughput is 1 transaction/cycle.
- Read after write to the same word on consecutive cycles: the load returns the stored data.
- Reset mid-operation: all in-flight transactions are dropped and no `data_ok` is emitted for them. RAM contents are not cleared. Writes accepted before reset remain.
- RAM is uninitialised after power-up and is never reset.

## Configuration
- `DSRAM_STALL_EN` defined: a 16-bit LFSR (seed 16'hACE1, reset by `rst`, taps 16,14,13,11) advances every cycle. `data_addr_ok_o` is forced low whenever LFSR[1:0]==2'b00. This exercises MEM1 request retry and MEM2 `data_ok` waiting. Response latency after acceptance is unchanged.
- `DSRAM_STALL_EN` undefined: `data_addr_ok_o` is constant 1 outside reset, and no LFSR logic is present.

## Structure
- Shared package / header `cpu.vh`:
  - size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`;
  - LFSR seed constant;
  - `RstEnable` (already present).
- One sub-module, `dsram_resp_pipe`: a parameterised LATENCY-stage valid+data shift line with synchronous active-low clear.
- The RAM array, byte-enable decode and the handshake stay in the top module.

## Test plan
- Reset then idle: hold `rst`=0 for 3 cycles, then release.
  - During reset, `data_addr_ok_o`=0 and `data_data_ok_o`=0.
  - After release, `addr_ok`=1 and no `data_ok` ever appears while idle.
- Word store/load, LATENCY=2:
  - Store word 32'hDEADBEEF at 0x100 at edge N, get `data_ok` after edge N+1.
  - Load 0x100 at edge N+1, get `data_ok` after edge N+2 with `rdata`=32'hDEADBEEF.
- Byte and half lanes:
  - Preload 0x200 = 32'h00000000.
  - Store byte 32'h0000AB00 at 0x201, then half 32'h12340000 at 0x202.
  - A load of 0x200 returns 32'h1234AB00.
- Streaming: 8 back-to-back loads of distinct preloaded words.
  - Expect 8 consecutive `data_ok` pulses, in order, starting LATENCY cycles after the first acceptance.
- Reset mid-flight: accept 2 loads, then assert `rst` on the next edge.
  - No `data_ok` appears for either load.
  - Previously written RAM data survives.
- With `DSRAM_STALL_EN` defined: hold `data_req_i` high for 200 cycles.
  - Accepted count equals the number of cycles with `addr_ok`=1.
  - Every accepted request yields exactly one `data_ok`, in order.

Source files
------------

// File: rtl/dsram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder.
// Combinational helpers only; no state.
// No flow control here; see the users of these definitions.
package dsram_responder_pkg;

    localparam logic        RstEnable = 1'b0;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    // Reserved size 11 falls into the default arm and behaves as a word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size_e'(size))
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dsram_resp_pipe.sv
// Valid+data shift line carrying responses back to the requester.
// Latency: LATENCY cycles from in_vld to out_vld.
// No backpressure: advances every cycle; synchronous active-low clear.
module dsram_resp_pipe
    import dsram_responder_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_dat,
    output logic          out_vld,
    output logic [DW-1:0] out_dat
);

    logic [LATENCY-1:0] vld_q;
    logic [DW-1:0]      dat_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            dat_q[0] <= in_dat;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[LATENCY-1];
    assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/dsram_responder.sv
// Word-addressed data RAM answering req/addr_ok/data_ok; option DSRAM_STALL_EN adds LFSR stalls.
// Latency: data_ok LATENCY cycles after acceptance, strictly in order.
// Backpressure: only via addr_ok (pseudo-random when stalling); data_ok cannot be held off.
module dsram_responder
    import dsram_responder_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic              ready_q;
    logic              stall;
    logic              acc_vld;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;
    logic [31:0]       rd_dat;
    logic              unused_addr;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

`ifdef DSRAM_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign data_addr_ok_o = ready_q & ~stall;

    // Gating with rst keeps the edge that enters reset from writing the RAM.
    assign acc_vld = data_req_i & data_addr_ok_o & (rst != RstEnable);
    assign idx     = data_addr_i[ADDR_W+1:2];
    assign be      = byte_en(data_size_i, data_addr_i[1:0]);

    // Upper address bits alias by design.
    assign unused_addr = ^data_addr_i[31:ADDR_W+2];

    always_ff @(posedge clk) begin
        if (acc_vld && data_wr_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Stores and idle slots carry zero so rdata is quiet outside load responses.
    assign rd_dat = (acc_vld && !data_wr_i) ? mem[idx] : 32'h0;

    dsram_resp_pipe #(
        .LATENCY (LATENCY),
        .DW      (32)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (acc_vld),
        .in_dat  (rd_dat),
        .out_vld (data_data_ok_o),
        .out_dat (data_rdata_o)
    );

endmodule
